// File: rtl/hf_spi_cmd_rx.sv
// hf_spi_cmd_rx
// ----------------------------------------------------------------------------
// Receiver for the 16-bit ARM->FPGA SPI command channel of the HF image.
// The SPI pins are asynchronous to ck_1356meg.  They are oversampled through
// two-flop synchronisers.  Each frame framed by ncs is assembled MSB first and
// length-checked.  The frame is then decoded into the registered configuration
// outputs consumed by the HF mode muxing.
//
// Build option: define HF_SPI_ERRCNT_EN to add the err_count port and its
// saturating rejected-frame counter.  Without it the port is absent and all
// other behaviour is identical.
//
// Ports
//   ck_1356meg    in   sole clock, rising edge
//   rst           in   asynchronous active-high reset
//   spck          in   ARM SPI clock (async, <= f/4, each phase >= 2 ck)
//   mosi          in   ARM SPI data, MSB first (async)
//   ncs           in   ARM SPI chip select, active low (async)
//   conf_word     out  last accepted SET_CONFREG payload
//   trace_enable  out  last accepted TRACE_ENABLE bit
//   cmd_valid     out  one-cycle pulse per accepted frame
//   cmd           out  command nibble of the last accepted frame
//   cmd_data      out  low 12 bits of the last accepted frame
//   frame_err     out  one-cycle pulse per rejected frame
//   err_count     out  saturating rejected-frame count (HF_SPI_ERRCNT_EN only)
// ----------------------------------------------------------------------------
module hf_spi_cmd_rx #(
    parameter int FRAME_BITS = 16,
    parameter int CONF_BITS  = 9
) (
    input  logic                 ck_1356meg,
    input  logic                 rst,
    input  logic                 spck,
    input  logic                 mosi,
    input  logic                 ncs,
    output logic [CONF_BITS-1:0] conf_word,
    output logic                 trace_enable,
    output logic                 cmd_valid,
    output logic [3:0]           cmd,
    output logic [11:0]          cmd_data,
    output logic                 frame_err
`ifdef HF_SPI_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam int          CW               = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] BITS_FULL      = CW'(FRAME_BITS);
    localparam logic [CW-1:0] BITS_OVF       = CW'(FRAME_BITS + 1);
    localparam logic [3:0]  CMD_SET_CONFREG  = 4'd1;
    localparam logic [3:0]  CMD_TRACE_ENABLE = 4'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers.  Bit 0 is the first flop, bit 1 the synchronised
    // value, bit 2 (spck/ncs only) the history flop for edge detection.
    // ncs resets to 1 so that reset release never looks like a frame start.
    // ------------------------------------------------------------------
    logic [2:0] spck_q;
    logic [2:0] ncs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            spck_q <= 3'b000;
            ncs_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            spck_q <= {spck_q[1:0], spck};
            ncs_q  <= {ncs_q[1:0], ncs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    logic spck_rise;
    logic ncs_fall;
    logic ncs_rise;
    logic mosi_s;

    assign spck_rise = spck_q[1] & ~spck_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
    assign mosi_s    = mosi_q[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    // Remembers an ncs fall seen during DONE so the frame is not lost.
    logic                  start_pend_q, start_pend_d;
    logic [CONF_BITS-1:0]  conf_q, conf_d;
    logic                  trace_q, trace_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [11:0]           data_q, data_d;
`ifdef HF_SPI_ERRCNT_EN
    logic [7:0]            errcnt_q, errcnt_d;
`endif

    // State register
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall || start_pend_q) state_d = SHIFT;
            SHIFT:   if (ncs_rise)                 state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.  The decode result is registered on the edge
    // that enters DONE.  The pulses are therefore high exactly during the
    // DONE cycle, three ck edges after the ncs pin rises.
    always_comb begin
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        start_pend_d = start_pend_q;
        conf_d       = conf_q;
        trace_d      = trace_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        ferr_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall || start_pend_q) begin
                    shift_d      = '0;
                    bitcnt_d     = '0;
                    start_pend_d = 1'b0;
                end
            end
            SHIFT: begin
                // ncs rise takes priority: a coincident spck edge is dropped.
                if (ncs_rise) begin
                    if (bitcnt_q == BITS_FULL) begin
                        valid_d = 1'b1;
                        cmd_d   = shift_q[FRAME_BITS-1 -: 4];
                        data_d  = shift_q[11:0];
                        if (shift_q[FRAME_BITS-1 -: 4] == CMD_SET_CONFREG) begin
                            conf_d = shift_q[CONF_BITS-1:0];
                        end
                        if (shift_q[FRAME_BITS-1 -: 4] == CMD_TRACE_ENABLE) begin
                            trace_d = shift_q[0];
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (spck_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
                    // Saturates one past a full frame so overflow stays visible.
                    if (bitcnt_q != BITS_OVF) begin
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (ncs_fall) start_pend_d = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef HF_SPI_ERRCNT_EN
    always_comb begin
        errcnt_d = errcnt_q;
        if (ferr_d && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            errcnt_q <= 8'd0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count = errcnt_q;
`endif

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            bitcnt_q     <= '0;
            start_pend_q <= 1'b0;
            conf_q       <= '0;
            trace_q      <= 1'b0;
            cmd_q        <= 4'd0;
            data_q       <= 12'd0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            start_pend_q <= start_pend_d;
            conf_q       <= conf_d;
            trace_q      <= trace_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
        end
    end

    assign conf_word    = conf_q;
    assign trace_enable = trace_q;
    assign cmd_valid    = valid_q;
    assign cmd          = cmd_q;
    assign cmd_data     = data_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_hf_spi_cmd_rx.sv
// Testbench for hf_spi_cmd_rx.  SPI pins are driven on the falling clock
// edge.  A frame-level model predicts every output and is compared each
// cycle, 1 time unit after the rising edge.
module tb_hf_spi_cmd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spck = 1'b0;
    logic       mosi = 1'b0;
    logic       ncs = 1'b1;
    logic [8:0] conf_word;
    logic       trace_enable;
    logic       cmd_valid;
    logic [3:0] cmd;
    logic [11:0] cmd_data;
    logic       frame_err;
`ifdef HF_SPI_ERRCNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    hf_spi_cmd_rx #(.FRAME_BITS(16), .CONF_BITS(9)) dut (
        .ck_1356meg   (clk),
        .rst          (rst),
        .spck         (spck),
        .mosi         (mosi),
        .ncs          (ncs),
        .conf_word    (conf_word),
        .trace_enable (trace_enable),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .cmd_data     (cmd_data),
        .frame_err    (frame_err)
`ifdef HF_SPI_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        int          due;
        bit          ok;
        logic [15:0] val;
    } ev_t;
    ev_t evq[$];

    int          cyc = 0;
    logic [8:0]  m_conf;
    logic        m_trace;
    logic [3:0]  m_cmd;
    logic [11:0] m_data;
    int          m_errs;
    int          valid_seen = 0;
    int          last_valid_cyc = -1;
    int          last_rise_cyc = 0;

    initial begin
        forever begin
            bit exp_v;
            bit exp_e;
            @(posedge clk);
            cyc++;
            #1;
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (rst) begin
                m_conf = '0; m_trace = 1'b0; m_cmd = '0; m_data = '0; m_errs = 0;
                evq.delete();
            end else if (evq.size() > 0 && evq[0].due == cyc) begin
                ev_t ev;
                ev = evq.pop_front();
                if (ev.ok) begin
                    exp_v  = 1'b1;
                    m_cmd  = ev.val[15:12];
                    m_data = ev.val[11:0];
                    if (ev.val[15:12] == 4'd1) m_conf  = ev.val[8:0];
                    if (ev.val[15:12] == 4'd2) m_trace = ev.val[0];
                end else begin
                    exp_e = 1'b1;
                    if (m_errs < 255) m_errs++;
                end
            end
            if (cmd_valid === 1'b1) begin
                valid_seen++;
                last_valid_cyc = cyc;
            end
            chk("cmd_valid", 32'(cmd_valid), 32'(exp_v));
            chk("frame_err", 32'(frame_err), 32'(exp_e));
            chk("conf_word", 32'(conf_word), 32'(m_conf));
            chk("trace_enable", 32'(trace_enable), 32'(m_trace));
            chk("cmd", 32'(cmd), 32'(m_cmd));
            chk("cmd_data", 32'(cmd_data), 32'(m_data));
`ifdef HF_SPI_ERRCNT_EN
            chk("err_count", 32'(err_count), 32'(m_errs));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input int n, input logic [31:0] pat, input int h);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = pat[i];
            wait_cyc(h);
            spck = 1'b1;
            wait_cyc(h);
            spck = 1'b0;
        end
    endtask

    // Sends the low n bits of pat MSB first with spck half-period h ck.
    task automatic send_frame(input int n, input logic [31:0] pat, input int h);
        ev_t ev;
        @(negedge clk);
        ncs = 1'b0;
        wait_cyc(3);
        send_bits(n, pat, h);
        wait_cyc(h);
        ncs = 1'b1;
        last_rise_cyc = cyc;
        ev.due = cyc + 3;
        ev.ok  = (n == 16);
        ev.val = pat[15:0];
        evq.push_back(ev);
        wait_cyc(6);
    endtask

    initial begin
        wait_cyc(3);
        rst = 1'b0;

        // Idle after reset: nothing happens.
        wait_cyc(100);
        chk("idle_conf", 32'(conf_word), 32'h0);
        chk("idle_trace", 32'(trace_enable), 32'h0);
        chk("idle_no_valid", 32'(valid_seen), 32'h0);

        // SET_CONFREG 0x1155 at f/6.
        send_frame(16, 32'h1155, 3);
        chk("lit_conf_155", 32'(conf_word), 32'h155);
        chk("lit_cmd_1", 32'(cmd), 32'h1);
        chk("lit_data_155", 32'(cmd_data), 32'h155);
        chk("lit_latency", 32'(last_valid_cyc - last_rise_cyc), 32'd3);
        chk("lit_one_valid", 32'(valid_seen), 32'd1);

        // TRACE_ENABLE 1 then 0.
        send_frame(16, 32'h2001, 3);
        chk("lit_trace_1", 32'(trace_enable), 32'h1);
        chk("lit_conf_kept", 32'(conf_word), 32'h155);
        send_frame(16, 32'h2000, 2);
        chk("lit_trace_0", 32'(trace_enable), 32'h0);

        // Unknown command: valid only.
        send_frame(16, 32'h5ABC, 2);
        chk("lit_cmd_5", 32'(cmd), 32'h5);
        chk("lit_data_abc", 32'(cmd_data), 32'hABC);
        chk("lit_conf_kept2", 32'(conf_word), 32'h155);

        // Short and long frames are rejected.
        send_frame(15, 32'h1234, 3);
        send_frame(17, 32'h11155, 3);
        chk("lit_conf_after_err", 32'(conf_word), 32'h155);
        chk("lit_cmd_after_err", 32'(cmd), 32'h5);
`ifdef HF_SPI_ERRCNT_EN
        chk("lit_errcnt_2", 32'(err_count), 32'd2);
`endif

        // Reset after 8 bits of 0x1155, then a full 0x10AA frame.
        @(negedge clk);
        ncs = 1'b0;
        wait_cyc(3);
        send_bits(8, 32'h11, 3);
        rst = 1'b1;
        ncs = 1'b1;
        mosi = 1'b0;
        wait_cyc(2);
        chk("lit_rst_conf", 32'(conf_word), 32'h0);
        rst = 1'b0;
        wait_cyc(5);
        send_frame(16, 32'h10AA, 3);
        chk("lit_conf_0aa", 32'(conf_word), 32'h0AA);
        chk("lit_data_0aa", 32'(cmd_data), 32'h0AA);
`ifdef HF_SPI_ERRCNT_EN
        chk("lit_errcnt_0", 32'(err_count), 32'd0);
`endif

        // 300 empty frames: counter saturates.
        for (int i = 0; i < 300; i++) begin
            send_frame(0, 32'h0, 2);
        end
        chk("lit_conf_after_many", 32'(conf_word), 32'h0AA);
`ifdef HF_SPI_ERRCNT_EN
        chk("lit_errcnt_255", 32'(err_count), 32'd255);
`endif
        wait_cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
